// File: rtl/integrator_chain.sv
// CIFB integrator cascade for the delta-sigma loop filter: ORDER stages, each
// subtracting the quantiser feedback, with clamp-or-wrap arithmetic, a sticky
// per-stage overflow flag and a one-cycle valid strobe after each sample.
module integrator_chain #(
    parameter int unsigned IN_WIDTH  = 4,
    parameter int unsigned ORDER     = 2,
    parameter int unsigned ACC_WIDTH = IN_WIDTH + 2 * ORDER,
    parameter bit          SATURATE  = 1'b1
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_sample,
    input  logic                         i_clear,
    input  logic                         i_ovf_clr,
    input  logic [IN_WIDTH-1:0]          i_data,
    input  logic [IN_WIDTH-1:0]          i_fb,
    output logic [ACC_WIDTH-1:0]         o_data,
    output logic [ORDER*ACC_WIDTH-1:0]   o_stage,
    output logic                         o_valid,
    output logic [ORDER-1:0]             o_ovf
);

    // Two guard bits: the sum of three ACC_WIDTH-range terms never wraps here.
    localparam int unsigned EXT_WIDTH = ACC_WIDTH + 2;
    localparam logic signed [EXT_WIDTH-1:0] MAX_EXT = {3'b000, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [EXT_WIDTH-1:0] MIN_EXT = {3'b111, {(ACC_WIDTH-1){1'b0}}};

    logic [ORDER-1:0][ACC_WIDTH-1:0] acc_q, acc_d;
    logic [ORDER-1:0]                ovf_q, ovf_d;
    logic                            valid_q, valid_d;

    logic signed [EXT_WIDTH-1:0]     data_ext;
    logic signed [EXT_WIDTH-1:0]     fb_ext;
    logic signed [EXT_WIDTH-1:0]     prev_ext [ORDER];
    logic signed [EXT_WIDTH-1:0]     sum_ext  [ORDER];
    logic [ORDER-1:0][ACC_WIDTH-1:0] stage_res;
    logic [ORDER-1:0]                ovf_hit;
    logic [ORDER-1:0]                ovf_set;
    logic                            accept;

    // Per-stage wide sums from pre-edge values, then clamp or wrap.
    always_comb begin
        data_ext    = EXT_WIDTH'($signed(i_data));
        fb_ext      = EXT_WIDTH'($signed(i_fb));
        prev_ext[0] = data_ext;
        for (int k = 1; k < ORDER; k++) begin
            prev_ext[k] = EXT_WIDTH'($signed(acc_q[k-1]));
        end
        for (int k = 0; k < ORDER; k++) begin
            sum_ext[k] = EXT_WIDTH'($signed(acc_q[k])) + prev_ext[k] - fb_ext;
            ovf_hit[k] = (sum_ext[k] > MAX_EXT) || (sum_ext[k] < MIN_EXT);
            if (SATURATE && (sum_ext[k] > MAX_EXT)) begin
                stage_res[k] = ACC_WIDTH'(MAX_EXT);
            end else if (SATURATE && (sum_ext[k] < MIN_EXT)) begin
                stage_res[k] = ACC_WIDTH'(MIN_EXT);
            end else begin
                stage_res[k] = ACC_WIDTH'(sum_ext[k]);
            end
        end
    end

    // Next state: clear beats sample; a new overflow beats the flag clear.
    always_comb begin
        accept  = i_sample & ~i_clear;
        acc_d   = acc_q;
        valid_d = accept;
        ovf_set = accept ? ovf_hit : '0;
        ovf_d   = i_ovf_clr ? ovf_set : (ovf_q | ovf_set);
        if (i_clear) begin
            acc_d = '0;
        end else if (i_sample) begin
            acc_d = stage_res;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            acc_q   <= '0;
            ovf_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
        end
    end

    assign o_stage = acc_q;
    assign o_data  = acc_q[ORDER-1];
    assign o_valid = valid_q;
    assign o_ovf   = ovf_q;

endmodule

// File: tb/tb_integrator_chain.sv
// Directed bench: a saturating and a wrapping instance driven by the same stimulus.
module tb_integrator_chain;

    localparam int unsigned IW  = 4;
    localparam int unsigned ORD = 2;
    localparam int unsigned AW  = 8;

    logic          clk;
    logic          rst_n;
    logic          sample;
    logic          clear;
    logic          ovf_clr;
    logic [IW-1:0] data;
    logic [IW-1:0] fb;

    logic [AW-1:0]     data_s, data_w;
    logic [ORD*AW-1:0] stage_s, stage_w;
    logic              valid_s, valid_w;
    logic [ORD-1:0]    ovf_s, ovf_w;

    int errors = 0;
    int checks = 0;

    integrator_chain #(.IN_WIDTH(IW), .ORDER(ORD), .ACC_WIDTH(AW), .SATURATE(1'b1)) u_sat (
        .i_clk(clk), .i_rst_n(rst_n), .i_sample(sample), .i_clear(clear),
        .i_ovf_clr(ovf_clr), .i_data(data), .i_fb(fb),
        .o_data(data_s), .o_stage(stage_s), .o_valid(valid_s), .o_ovf(ovf_s)
    );

    integrator_chain #(.IN_WIDTH(IW), .ORDER(ORD), .ACC_WIDTH(AW), .SATURATE(1'b0)) u_wrap (
        .i_clk(clk), .i_rst_n(rst_n), .i_sample(sample), .i_clear(clear),
        .i_ovf_clr(ovf_clr), .i_data(data), .i_fb(fb),
        .o_data(data_w), .o_stage(stage_w), .o_valid(valid_w), .o_ovf(ovf_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int sx(input logic [ORD*AW-1:0] st, input int k);
        logic [AW-1:0] b;
        b = st[k*AW +: AW];
        return int'($signed(b));
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // which: 0 = saturating instance, 1 = wrapping instance
    task automatic chk_dut(input string tag, input int which, input int e0, input int e1,
                           input int ev, input int eovf);
        if (which == 0) begin
            chk({tag, "/sat/s0"},    sx(stage_s, 0), e0);
            chk({tag, "/sat/s1"},    sx(stage_s, 1), e1);
            chk({tag, "/sat/odata"}, int'($signed(data_s)), e1);
            chk({tag, "/sat/valid"}, int'(valid_s), ev);
            chk({tag, "/sat/ovf"},   int'(ovf_s), eovf);
        end else begin
            chk({tag, "/wrap/s0"},    sx(stage_w, 0), e0);
            chk({tag, "/wrap/s1"},    sx(stage_w, 1), e1);
            chk({tag, "/wrap/odata"}, int'($signed(data_w)), e1);
            chk({tag, "/wrap/valid"}, int'(valid_w), ev);
            chk({tag, "/wrap/ovf"},   int'(ovf_w), eovf);
        end
    endtask

    task automatic chk_both(input string tag, input int e0, input int e1,
                            input int ev, input int eovf);
        chk_dut(tag, 0, e0, e1, ev, eovf);
        chk_dut(tag, 1, e0, e1, ev, eovf);
    endtask

    task automatic cyc(input logic smp, input logic clr, input logic oc, input int d, input int f);
        sample  = smp;
        clear   = clr;
        ovf_clr = oc;
        data    = IW'(d);
        fb      = IW'(f);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 0, 0);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; sample = 1'b0; clear = 1'b0; ovf_clr = 1'b0; data = '0; fb = '0;

        // Reset held with random inputs toggling
        for (int i = 0; i < 4; i++) begin
            cyc(1'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 15)),
                int'($urandom_range(0, 15)));
        end
        chk_both("reset", 0, 0, 0, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b0, 1'b0, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
        end
        chk_both("idle", 0, 0, 0, 0);

        // Step response: (s0,s1) = (1,0),(2,1),(3,3),(4,6)
        cyc(1'b1, 1'b0, 1'b0, 1, 0); chk_both("step1", 1, 0, 1, 0);
        cyc(1'b1, 1'b0, 1'b0, 1, 0); chk_both("step2", 2, 1, 1, 0);
        cyc(1'b1, 1'b0, 1'b0, 1, 0); chk_both("step3", 3, 3, 1, 0);
        cyc(1'b1, 1'b0, 1'b0, 1, 0); chk_both("step4", 4, 6, 1, 0);
        cyc(1'b0, 1'b0, 1'b0, 1, 0); chk_both("hold",  4, 6, 0, 0);

        // Clear wins over a simultaneous sample
        cyc(1'b1, 1'b1, 1'b0, 1, 0); chk_both("clear", 0, 0, 0, 0);

        // Asynchronous reset between edges, then the step sequence resumes
        cyc(1'b1, 1'b0, 1'b0, 1, 0); chk_both("mid1", 1, 0, 1, 0);
        cyc(1'b1, 1'b0, 1'b0, 1, 0); chk_both("mid2", 2, 1, 1, 0);
        #2 rst_n = 1'b0;
        #1 chk_both("async_rst", 0, 0, 0, 0);
        rst_n = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 1, 0); chk_both("resume1", 1, 0, 1, 0);
        cyc(1'b1, 1'b0, 1'b0, 1, 0); chk_both("resume2", 2, 1, 1, 0);

        // Feedback: data=fb=3 keeps s0 at 0, s1 falls by 3 per sample
        do_reset();
        for (int n = 1; n <= 42; n++) cyc(1'b1, 1'b0, 1'b0, 3, 3);
        chk_both("fb42", 0, -126, 1, 0);
        cyc(1'b1, 1'b0, 1'b0, 3, 3);
        chk_dut("fb43", 0, 0, -128, 1, 2);
        chk_dut("fb43", 1, 0, 127, 1, 2);
        cyc(1'b1, 1'b0, 1'b0, 3, 3);
        chk_dut("fb44", 0, 0, -128, 1, 2);
        chk_dut("fb44", 1, 0, 124, 1, 2);
        // Flag clear coinciding with a new stage-1 overflow (sat only overflows)
        cyc(1'b1, 1'b0, 1'b1, 3, 3);
        chk_dut("ovfclr_set", 0, 0, -128, 1, 2);
        chk_dut("ovfclr_set", 1, 0, 121, 1, 0);
        cyc(1'b0, 1'b0, 1'b1, 3, 3);
        chk_dut("ovfclr", 0, 0, -128, 0, 0);
        chk_dut("ovfclr", 1, 0, 121, 0, 0);

        // Wrap vs clamp: data=7, fb=0 -> s0=7n, s1=7n(n-1)/2
        do_reset();
        for (int n = 1; n <= 6; n++) cyc(1'b1, 1'b0, 1'b0, 7, 0);
        chk_both("ramp6", 42, 105, 1, 0);
        cyc(1'b1, 1'b0, 1'b0, 7, 0);
        chk_dut("ramp7", 0, 49, 127, 1, 2);
        chk_dut("ramp7", 1, 49, -109, 1, 2);
        cyc(1'b1, 1'b0, 1'b0, 7, 0);
        chk_dut("ramp8", 0, 56, 127, 1, 2);
        chk_dut("ramp8", 1, 56, -60, 1, 2);
        for (int n = 9; n <= 18; n++) cyc(1'b1, 1'b0, 1'b0, 7, 0);
        chk("ramp18/sat/s0",  sx(stage_s, 0), 126);
        chk("ramp18/wrap/s0", sx(stage_w, 0), 126);
        chk("ramp18/sat/ovf", int'(ovf_s), 2);
        cyc(1'b1, 1'b0, 1'b0, 7, 0);
        chk_dut("ramp19", 0, 127, 127, 1, 3);
        chk("ramp19/wrap/s0",  sx(stage_w, 0), -123);
        chk("ramp19/wrap/ovf", int'(ovf_w), 3);

        // Clear leaves sticky flags alone
        cyc(1'b1, 1'b1, 1'b0, 7, 0);
        chk_both("clear_ovf", 0, 0, 0, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
